// File: rtl/window_pkg.sv
// Shared widths and pixel/window types for the 3x3 streaming window datapath.
package window_pkg;

    localparam int PIX_W_DEF = 8;
    localparam int IMG_W_DEF = 258;
    localparam int IMG_H_DEF = 258;

    typedef logic [PIX_W_DEF-1:0] pixel_t;
    typedef pixel_t [8:0]         window_t;

endpackage

// File: rtl/line_buffer.sv
// One padded image line of storage: combinational read, synchronous write.
// A write returns the old word on the same cycle, so each entry can be read and replaced in one accept.
module line_buffer #(
    parameter int DEPTH = 258,
    parameter int WIDTH = 8,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic [AW-1:0]    i_addr,
    input  logic             i_we,
    input  logic [WIDTH-1:0] i_wdat,
    output logic [WIDTH-1:0] o_rdat
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdat;
        end
    end

    assign o_rdat = r_mem[i_addr];

endmodule

// File: rtl/window3x3_stream.sv
// Streams a raster, pre-padded image and emits each complete 3x3 neighbourhood one cycle after its newest pixel.
// A held (valid, not ready) window freezes all state and deasserts in_ready.
module window3x3_stream
    import window_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [PIX_W-1:0] out_p1,
    output logic [PIX_W-1:0] out_p2,
    output logic [PIX_W-1:0] out_p3,
    output logic [PIX_W-1:0] out_p4,
    output logic [PIX_W-1:0] out_p5,
    output logic [PIX_W-1:0] out_p6,
    output logic [PIX_W-1:0] out_p7,
    output logic [PIX_W-1:0] out_p8,
    output logic [PIX_W-1:0] out_p9,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [PIX_W-1:0] r_win [9];
    logic             r_out_vld;
    logic             r_out_last;

    logic             w_in_rdy;
    logic             w_accept;
    logic             w_qual;
    logic             w_last;
    logic [PIX_W-1:0] w_lb0;
    logic [PIX_W-1:0] w_lb1;

    assign w_in_rdy = !r_out_vld || out_ready;
    assign w_accept = in_valid && w_in_rdy && !clear;
    // Columns/rows 0 and 1 only prime the window; they never hold a full neighbourhood.
    assign w_qual   = (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));
    assign w_last   = (r_row == ROW_W'(IMG_H - 1)) && (r_col == COL_W'(IMG_W - 1));

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(COL_W)) u_lb0 (
        .clk    (clk),
        .i_addr (r_col),
        .i_we   (w_accept),
        .i_wdat (in_pixel),
        .o_rdat (w_lb0)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(COL_W)) u_lb1 (
        .clk    (clk),
        .i_addr (r_col),
        .i_we   (w_accept),
        .i_wdat (w_lb0),
        .o_rdat (w_lb1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col      <= '0;
            r_row      <= '0;
            r_out_vld  <= 1'b0;
            r_out_last <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                r_win[i] <= '0;
            end
        end else if (clear) begin
            r_col      <= '0;
            r_row      <= '0;
            r_out_vld  <= 1'b0;
            r_out_last <= 1'b0;
        end else begin
            if (w_accept) begin
                r_win[0] <= r_win[1];
                r_win[1] <= r_win[2];
                r_win[2] <= w_lb1;
                r_win[3] <= r_win[4];
                r_win[4] <= r_win[5];
                r_win[5] <= w_lb0;
                r_win[6] <= r_win[7];
                r_win[7] <= r_win[8];
                r_win[8] <= in_pixel;
                if (r_col == COL_W'(IMG_W - 1)) begin
                    r_col <= '0;
                    r_row <= (r_row == ROW_W'(IMG_H - 1)) ? '0 : r_row + ROW_W'(1);
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
            end
            if (w_accept && w_qual) begin
                r_out_vld  <= 1'b1;
                r_out_last <= w_last;
            end else if (out_ready) begin
                r_out_vld  <= 1'b0;
                r_out_last <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_rdy;
    assign out_valid = r_out_vld;
    assign out_last  = r_out_last;
    assign out_p1    = r_win[0];
    assign out_p2    = r_win[1];
    assign out_p3    = r_win[2];
    assign out_p4    = r_win[3];
    assign out_p5    = r_win[4];
    assign out_p6    = r_win[5];
    assign out_p7    = r_win[6];
    assign out_p8    = r_win[7];
    assign out_p9    = r_win[8];

endmodule

// File: tb/tb_window3x3_stream.sv
// Randomised bench for window3x3_stream: small 5x4 instance for flow-control scenarios, default 258x258 instance for a full frame.
module tb_window3x3_stream;

    localparam int SW = 5;
    localparam int SH = 4;
    localparam int BW = 258;
    localparam int BH = 258;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // small instance
    logic       clear, in_valid, in_ready, out_valid, out_ready, out_last;
    logic [7:0] in_pixel;
    logic [7:0] o1, o2, o3, o4, o5, o6, o7, o8, o9;
    // default-size instance
    logic       b_clear, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
    logic [7:0] b_in_pixel;
    logic [7:0] b1, b2, b3, b4, b5, b6, b7, b8, b9;

    window3x3_stream #(.PIX_W(8), .IMG_W(SW), .IMG_H(SH)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
        .out_p1(o1), .out_p2(o2), .out_p3(o3), .out_p4(o4), .out_p5(o5),
        .out_p6(o6), .out_p7(o7), .out_p8(o8), .out_p9(o9),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    window3x3_stream dut_big (
        .clk(clk), .rst(rst), .clear(b_clear),
        .in_pixel(b_in_pixel), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_p1(b1), .out_p2(b2), .out_p3(b3), .out_p4(b4), .out_p5(b5),
        .out_p6(b6), .out_p7(b7), .out_p8(b8), .out_p9(b9),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_last(b_out_last)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] spix(input int base, input int r, input int c);
        return 8'(base + r * 16 + c);
    endfunction

    function automatic logic [7:0] bpix(input int r, input int c);
        return 8'(r * 13 + c);
    endfunction

    // window whose newest pixel is (r,c), packed {p1..p9, last}
    function automatic logic [72:0] swin(input int base, input int r, input int c);
        logic [71:0] v;
        v = '0;
        for (int i = 0; i < 9; i++) v[71 - 8*i -: 8] = spix(base, r - 2 + i / 3, c - 2 + i % 3);
        return {v, (r == SH - 1) && (c == SW - 1)};
    endfunction

    function automatic logic [72:0] bwin(input int r, input int c);
        logic [71:0] v;
        v = '0;
        for (int i = 0; i < 9; i++) v[71 - 8*i -: 8] = bpix(r - 2 + i / 3, c - 2 + i % 3);
        return {v, (r == BH - 1) && (c == BW - 1)};
    endfunction

    logic [72:0] exp_q[$];

    task automatic expect_frame(input int base);
        for (int r = 2; r < SH; r++)
            for (int c = 2; c < SW; c++)
                exp_q.push_back(swin(base, r, c));
    endtask

    // ---------------- monitors ----------------
    logic [72:0] cur, prev_obs;
    bit          prev_stall = 0;
    int          win_cnt    = 0;
    assign cur = {o1, o2, o3, o4, o5, o6, o7, o8, o9, out_last};

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) check_eq("stall_hold", {cur, out_valid}, {prev_obs, 1'b1});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check_eq("unexpected_window", cur, '0);
                else check_eq($sformatf("window%0d", win_cnt), cur, exp_q.pop_front());
                win_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_obs   = cur;
        end
    end

    int b_cnt = 0;
    always @(negedge clk) begin
        if (!rst && b_out_valid && b_out_ready) begin
            if (b_cnt >= (BW - 2) * (BH - 2))
                check_eq("big_extra_window", b_cnt, (BW - 2) * (BH - 2) - 1);
            else
                check_eq($sformatf("big_window%0d", b_cnt),
                         {b1, b2, b3, b4, b5, b6, b7, b8, b9, b_out_last},
                         bwin(b_cnt / (BW - 2) + 2, b_cnt % (BW - 2) + 2));
            b_cnt++;
        end
    end

    // ---------------- driver ----------------
    bit ready_toggle = 0;
    bit gap_en       = 0;

    task automatic send_px(input logic [7:0] v);
        int  budget;
        bit  done;
        budget = 200;
        done   = 0;
        while (!done) begin
            @(posedge clk); #1;
            clear     = 1'b0;
            out_ready = ready_toggle ? ~out_ready : 1'b1;
            if (gap_en && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_pixel = v;
            end
            @(negedge clk);
            if (in_valid && in_ready) done = 1;
            budget--;
            if (!done && budget == 0) begin
                check_eq("in_ready_timeout", 0, 1);
                done = 1;
            end
        end
    endtask

    task automatic send_frame(input int base);
        for (int i = 0; i < SW * SH; i++) send_px(spix(base, i / SW, i % SW));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_valid  = 1'b0;
            clear     = 1'b0;
            out_ready = 1'b1;
        end
    endtask

    task automatic finish_scenario(input string tag, input int n_exp);
        idle(6);
        check_eq({tag, "_pending"}, exp_q.size(), 0);
        check_eq({tag, "_count"}, win_cnt, n_exp);
        exp_q.delete();
        win_cnt = 0;
    endtask

    initial begin
        int stallc;
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_pixel = '0; out_ready = 1'b1;
        b_clear = 1'b0; b_in_valid = 1'b0; b_in_pixel = '0; b_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_outputs", {cur, out_valid}, '0);
        check_eq("reset_in_ready", in_ready, 1);
        check_eq("reset_big_valid", b_out_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // full-rate single frame
        expect_frame(0);
        send_frame(0);
        finish_scenario("full_rate", 6);

        // toggled out_ready and random input gaps
        ready_toggle = 1; gap_en = 1;
        expect_frame(0);
        send_frame(0);
        finish_scenario("stalled", 6);
        ready_toggle = 0; gap_en = 0;

        // two back-to-back frames
        expect_frame(0);
        expect_frame(8'h80);
        send_frame(0);
        send_frame(8'h80);
        finish_scenario("two_frames", 12);

        // asynchronous reset mid-frame
        for (int i = 0; i < 7; i++) send_px(spix(0, i / SW, i % SW));
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        check_eq("midreset_outputs", {cur, out_valid}, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_reset_in_ready", in_ready, 1);
        expect_frame(0);
        send_frame(0);
        finish_scenario("after_reset", 6);

        // clear coincident with pixel 12 drops it and restarts the frame
        for (int i = 0; i < 12; i++) send_px(spix(0, i / SW, i % SW));
        @(posedge clk); #1;
        clear = 1'b1; in_valid = 1'b1; in_pixel = spix(0, 2, 2); out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_eq("clear_out_valid", out_valid, 0);
        expect_frame(8'h40);
        send_frame(8'h40);
        finish_scenario("after_clear", 6);

        // default-size ramp frame
        stallc = 0;
        for (int i = 0; i < BW * BH;) begin
            @(posedge clk); #1;
            b_in_valid = 1'b1;
            b_in_pixel = bpix(i / BW, i % BW);
            @(negedge clk);
            if (b_in_ready) begin
                i++;
            end else begin
                stallc++;
                if (stallc > 100) begin
                    check_eq("big_in_ready_timeout", 0, 1);
                    break;
                end
            end
        end
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("big_window_count", b_cnt, (BW - 2) * (BH - 2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
